wb_stage: RTL and testbench

Writeback stage directly downstream of the memory stage. It consumes the registered load data, the ALU result, the control bits and the destination register from MEM. It produces the single register-file write port, a registered forwarding copy for the decode/EX hazard logic, and retire/squash counters. It also owns the branch-shadow write-suppression counter, which replaces the ad-hoc 3-deep flop chain.

---
 rtl/wb_stage.sv | 143 ++++++++++++++
 tb/tb_wb_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage sitting directly after MEM. Selects load data or ALU result
// for the single register-file write port, keeps a registered copy of that
// write for the decode/EX forwarding logic, counts retired and squashed writes,
// and owns the branch-shadow counter that suppresses register writes for a
// fixed number of cycles after a taken branch.
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   i_hold             pipeline freeze: no write, all state holds
//   i_dout             registered load data from MEM
//   i_result_mem       registered ALU result from MEM
//   i_MemtoReg_mem     1 selects load data, 0 selects ALU result
//   i_RegWrite_mem     instruction in WB writes a register
//   i_towrite_mem      destination register index
//   i_branch_taken     taken branch resolved this cycle (single-cycle pulse)
//   i_init_delay       startup window, shadow logic held idle while high
//   o_rf_we/waddr/wdata  register-file write port (combinational)
//   o_fwd_valid/rd/data  previous unheld cycle's write, registered
//   o_shadow_active    write-suppression window in progress
//   o_retired_cnt      writes actually performed (wraps)
//   o_squashed_cnt     writes suppressed by the branch shadow (wraps)
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int SHADOW_CYCLES = 3,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_hold,
  input  logic [31:0]      i_dout,
  input  logic [31:0]      i_result_mem,
  input  logic             i_MemtoReg_mem,
  input  logic             i_RegWrite_mem,
  input  logic [4:0]       i_towrite_mem,
  input  logic             i_branch_taken,
  input  logic             i_init_delay,
  output logic             o_rf_we,
  output logic [4:0]       o_rf_waddr,
  output logic [31:0]      o_rf_wdata,
  output logic             o_fwd_valid,
  output logic [4:0]       o_fwd_rd,
  output logic [31:0]      o_fwd_data,
  output logic             o_shadow_active,
  output logic [CNT_W-1:0] o_retired_cnt,
  output logic [CNT_W-1:0] o_squashed_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } shadowState_t;

  localparam logic [2:0] SC_LOAD = 3'(SHADOW_CYCLES);

  shadowState_t     r_state;
  shadowState_t     w_nextState;
  logic [2:0]       r_sc;
  logic [2:0]       w_nextSc;
  logic             w_wantWrite;
  logic             w_rfWe;
  logic             w_shadowActive;
  logic [31:0]      w_wdataSel;
  logic             r_fwdValid;
  logic [4:0]       r_fwdRd;
  logic [31:0]      r_fwdData;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_squashed;

  // Write port: r0 is hardwired, so a write to it is never requested.
  assign w_wdataSel     = i_MemtoReg_mem ? i_dout : i_result_mem;
  assign w_wantWrite    = i_RegWrite_mem && (i_towrite_mem != 5'd0);
  assign w_shadowActive = (r_state == SHADOW);
  assign w_rfWe         = w_wantWrite && !w_shadowActive && !i_hold;

  // Shadow next-state. The state leaves SHADOW on the edge where sc would hit
  // zero, so the window lasts exactly SHADOW_CYCLES unheld cycles starting the
  // cycle after the branch. A branch inside the window restarts the count.
  always_comb begin
    w_nextState = r_state;
    w_nextSc    = r_sc;
    if (!i_hold) begin
      if (i_init_delay) begin
        w_nextState = IDLE;
        w_nextSc    = 3'd0;
      end else if (i_branch_taken) begin
        w_nextState = SHADOW;
        w_nextSc    = SC_LOAD;
      end else if (r_state == SHADOW) begin
        if (r_sc <= 3'd1) begin
          w_nextState = IDLE;
          w_nextSc    = 3'd0;
        end else begin
          w_nextSc = r_sc - 3'd1;
        end
      end
    end
  end

  // Shadow state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sc    <= 3'd0;
    end else begin
      r_state <= w_nextState;
      r_sc    <= w_nextSc;
    end
  end

  // Forwarding copy and counters, all frozen while the pipeline is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwdValid <= 1'b0;
      r_fwdRd    <= 5'd0;
      r_fwdData  <= 32'd0;
      r_retired  <= '0;
      r_squashed <= '0;
    end else if (!i_hold) begin
      r_fwdValid <= w_rfWe;
      r_fwdRd    <= i_towrite_mem;
      r_fwdData  <= w_wdataSel;
      if (w_rfWe) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (w_wantWrite && w_shadowActive) begin
        r_squashed <= r_squashed + CNT_W'(1);
      end
    end
  end

  assign o_rf_we         = w_rfWe;
  assign o_rf_waddr      = i_towrite_mem;
  assign o_rf_wdata      = w_wdataSel;
  assign o_fwd_valid     = r_fwdValid;
  assign o_fwd_rd        = r_fwdRd;
  assign o_fwd_data      = r_fwdData;
  assign o_shadow_active = w_shadowActive;
  assign o_retired_cnt   = r_retired;
  assign o_squashed_cnt  = r_squashed;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Bench for wb_stage. The reference model tracks the branch shadow as a count
// of remaining suppressed cycles and derives every expected output from it.
// Counters are built 8 bits wide so that wrap-around is reachable quickly.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int SC   = 3;
  localparam int CW   = 8;
  localparam int VECW = 1 + 5 + 32 + 1 + 5 + 32 + 1 + CW + CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic [31:0]   dIn = '0;
  logic [31:0]   res = '0;
  logic          memToReg = 1'b0;
  logic          regWrite = 1'b0;
  logic [4:0]    rd = '0;
  logic          br = 1'b0;
  logic          initD = 1'b0;

  logic          rfWe;
  logic [4:0]    rfWaddr;
  logic [31:0]   rfWdata;
  logic          fwdValid;
  logic [4:0]    fwdRd;
  logic [31:0]   fwdData;
  logic          shadowActive;
  logic [CW-1:0] retiredCnt;
  logic [CW-1:0] squashedCnt;
  logic [VECW-1:0] dutVec;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          mFwdValid;
  logic [4:0]    mFwdRd;
  logic [31:0]   mFwdData;
  int            mRemain;
  logic [CW-1:0] mRet;
  logic [CW-1:0] mSq;

  wb_stage #(.SHADOW_CYCLES(SC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_hold(hold), .i_dout(dIn),
    .i_result_mem(res), .i_MemtoReg_mem(memToReg), .i_RegWrite_mem(regWrite),
    .i_towrite_mem(rd), .i_branch_taken(br), .i_init_delay(initD),
    .o_rf_we(rfWe), .o_rf_waddr(rfWaddr), .o_rf_wdata(rfWdata),
    .o_fwd_valid(fwdValid), .o_fwd_rd(fwdRd), .o_fwd_data(fwdData),
    .o_shadow_active(shadowActive), .o_retired_cnt(retiredCnt),
    .o_squashed_cnt(squashedCnt)
  );

  always #5 clk = ~clk;

  assign dutVec = {rfWe, rfWaddr, rfWdata, fwdValid, fwdRd, fwdData,
                   shadowActive, retiredCnt, squashedCnt};

  // Expected outputs straight from the behavioural rules
  function automatic logic modelWant();
    return regWrite && (rd != 5'd0);
  endfunction

  function automatic logic modelWe();
    return modelWant() && (mRemain == 0) && !hold;
  endfunction

  function automatic logic [VECW-1:0] expVec();
    return {modelWe(), rd, (memToReg ? dIn : res), mFwdValid, mFwdRd, mFwdData,
            (mRemain > 0), mRet, mSq};
  endfunction

  task automatic modelReset();
    mFwdValid = 1'b0;
    mFwdRd    = '0;
    mFwdData  = '0;
    mRemain   = 0;
    mRet      = '0;
    mSq       = '0;
  endtask

  // Drive one cycle's inputs just after the falling edge and let them settle
  task automatic applyStimulus(input logic rw, input logic mtr, input logic [4:0] a,
                               input logic [31:0] d, input logic [31:0] r,
                               input logic b, input logic id, input logic h);
    @(negedge clk);
    regWrite = rw; memToReg = mtr; rd = a; dIn = d; res = r;
    br = b; initD = id; hold = h;
    #1;
  endtask

  // Advance the model by the coming rising edge, then wait for it
  task automatic clockEdge();
    logic we;
    we = modelWe();
    if (!hold) begin
      if (we) mRet = mRet + 1'b1;
      if (modelWant() && (mRemain > 0)) mSq = mSq + 1'b1;
      mFwdValid = we;
      mFwdRd    = rd;
      mFwdData  = memToReg ? dIn : res;
      if (initD)          mRemain = 0;
      else if (br)        mRemain = SC;
      else if (mRemain > 0) mRemain = mRemain - 1;
    end
    @(posedge clk);
  endtask

  task automatic idleInputs();
    regWrite = 0; memToReg = 0; rd = 0; dIn = 0; res = 0;
    br = 0; initD = 0; hold = 0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    modelReset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    clockEdge();
  endtask

  // Reset values of every registered output
  task automatic test_reset();
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fwdValid, fwdRd, fwdData, shadowActive, retiredCnt, squashedCnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected 0",
               {fwdValid, fwdRd, fwdData, shadowActive, retiredCnt, squashedCnt});
    end
    clockEdge();
  endtask

  // ALU result written in the same cycle, forwarded one cycle later
  task automatic test_alu_write();
    applyStimulus(1, 0, 5'd5, 32'hAAAA_0000, 32'h1234, 0, 0, 0);
    checks++;
    if ({rfWe, rfWaddr, rfWdata} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++;
      $display("[TB] FAIL alu_write_port: got %h expected %h", {rfWe, rfWaddr, rfWdata},
               {1'b1, 5'd5, 32'h1234});
    end
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fwdValid, fwdRd, fwdData, retiredCnt} !== {1'b1, 5'd5, 32'h1234, 8'd1}) begin
      errors++;
      $display("[TB] FAIL alu_write_fwd: got %h expected %h", {fwdValid, fwdRd, fwdData, retiredCnt},
               {1'b1, 5'd5, 32'h1234, 8'd1});
    end
    clockEdge();
  endtask

  // Load data selection and the r0 write suppression
  task automatic test_load_write();
    logic [CW-1:0] retBefore;
    applyStimulus(1, 1, 5'd9, 32'hDEADBEEF, 32'h40, 0, 0, 0);
    checks++;
    if ({rfWe, rfWaddr, rfWdata} !== {1'b1, 5'd9, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL load_write_port: got %h expected %h", {rfWe, rfWaddr, rfWdata},
               {1'b1, 5'd9, 32'hDEADBEEF});
    end
    clockEdge();
    retBefore = mRet;
    applyStimulus(1, 0, 5'd0, 32'h1, 32'h2, 0, 0, 0);
    checks++;
    if (rfWe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r0_write_we: got %b expected 0", rfWe);
    end
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (retiredCnt !== retBefore) begin
      errors++;
      $display("[TB] FAIL r0_write_retired: got %0d expected %0d", retiredCnt, retBefore);
    end
    clockEdge();
  endtask

  // Single branch with a write every cycle
  task automatic test_branch_shadow();
    logic [5:0] weExp  = 6'b110001;
    logic [5:0] actExp = 6'b001110;
    logic [CW-1:0] sqStart = mSq;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 0, 5'd7, $urandom, $urandom, (k == 0), 0, 0);
      checks++;
      if ({rfWe, shadowActive} !== {weExp[k], actExp[k]} || dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL branch_shadow_c%0d: got %h expected %h", k, dutVec, expVec());
      end
      clockEdge();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (squashedCnt !== CW'(sqStart + 3)) begin
      errors++;
      $display("[TB] FAIL branch_squashed: got %0d expected %0d", squashedCnt, CW'(sqStart + 3));
    end
    clockEdge();
  endtask

  // Second branch inside the window restarts it
  task automatic test_rebranch();
    logic [7:0] actExp = 8'b00111110;
    logic [CW-1:0] sqStart = mSq;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 1, 5'd3, $urandom, $urandom, (k == 0 || k == 2), 0, 0);
      checks++;
      if (shadowActive !== actExp[k] || dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL rebranch_c%0d: got %h expected %h", k, dutVec, expVec());
      end
      clockEdge();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (squashedCnt !== CW'(sqStart + 5)) begin
      errors++;
      $display("[TB] FAIL rebranch_squashed: got %0d expected %0d", squashedCnt, CW'(sqStart + 5));
    end
    clockEdge();
  endtask

  // Hold for four cycles in the middle of a shadow window
  task automatic test_hold();
    logic [8:0] actExp = 9'b011111110;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, 0, 5'd12, $urandom, $urandom, (k == 0), 0, (k >= 2 && k <= 5));
      checks++;
      if (shadowActive !== actExp[k] || dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL hold_c%0d: got %h expected %h", k, dutVec, expVec());
      end
      if (hold) begin
        checks++;
        if (rfWe !== 1'b0) begin
          errors++;
          $display("[TB] FAIL hold_we_c%0d: got %b expected 0", k, rfWe);
        end
      end
      clockEdge();
    end
  endtask

  // Branch ignored during the startup window
  task automatic test_init_delay();
    applyStimulus(1, 0, 5'd4, 32'h11, 32'h22, 1, 1, 0);
    clockEdge();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, 5'd4, 32'h11, 32'h22, 0, 0, 0);
      checks++;
      if ({shadowActive, rfWe} !== 2'b01 || dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL init_delay_c%0d: got %h expected %h", k, dutVec, expVec());
      end
      clockEdge();
    end
  endtask

  // Reset asserted mid-cycle inside a shadow window
  task automatic test_async_reset();
    applyStimulus(1, 0, 5'd6, 0, 32'h77, 1, 0, 0);
    clockEdge();
    applyStimulus(1, 0, 5'd6, 0, 32'h78, 0, 0, 0);
    checks++;
    if (shadowActive !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_pre_shadow: got %b expected 1", shadowActive);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fwdValid, fwdRd, fwdData, shadowActive, retiredCnt, squashedCnt} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset_values: got %h expected 0",
               {fwdValid, fwdRd, fwdData, shadowActive, retiredCnt, squashedCnt});
    end
    idleInputs();
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    clockEdge();
    applyStimulus(1, 0, 5'd6, 0, 32'h99, 0, 0, 0);
    checks++;
    if (rfWe !== 1'b1 || dutVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL post_reset_write: got %h expected %h", dutVec, expVec());
    end
    clockEdge();
  endtask

  // Retired counter wraps with no saturation
  task automatic test_wrap();
    doReset();
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1, 0, 5'd1, 0, k, 0, 0, 0);
      clockEdge();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (retiredCnt !== 8'd44) begin
      errors++;
      $display("[TB] FAIL retired_wrap: got %0d expected 44", retiredCnt);
    end
    clockEdge();
  endtask

  // Random traffic against the model
  task automatic test_random();
    logic [4:0] a;
    for (int k = 0; k < 600; k++) begin
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom, $urandom,
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 4) == 0));
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL random_c%0d: got %h expected %h", k, dutVec, expVec());
      end
      clockEdge();
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_alu_write();
    test_load_write();
    test_branch_shadow();
    test_rebranch();
    test_hold();
    test_init_delay();
    test_async_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
